// File: rtl/wb_pkg.sv
// wb_pkg: shared widths and the writeback request type for the regfile write port
package wb_pkg;
    localparam int XLEN   = 64;
    localparam int REG_AW = 5;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_req_t;

    // x0 is hardwired to zero, so a request targeting it is consumed without a real write
    function automatic logic wb_writes(input wb_req_t r);
        return r.rd != '0;
    endfunction
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: strictly in-order buffer for long-latency writeback requests
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push_i,
    input  wb_req_t                    din_i,
    input  logic                       pop_i,
    output wb_req_t                    head_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    wb_req_t       mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign full_o  = count_q == CW'(DEPTH);
    assign empty_o = count_q == '0;
    assign count_o = count_q;
    assign head_o  = mem_q[rd_q];

    // Pointers wrap naturally at the power-of-two depth; occupancy is tracked separately
    always_comb begin
        do_push = push_i && !full_o;
        do_pop  = pop_i && !empty_o;
        wr_d    = do_push ? wr_q + AW'(1) : wr_q;
        rd_d    = do_pop ? rd_q + AW'(1) : rd_q;
        count_d = count_q + CW'(do_push) - CW'(do_pop);
    end

    // Pointer and occupancy registers; reset discards every buffered entry
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    // Entry storage needs no reset: only slots between the pointers are ever read
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din_i;
    end
endmodule

// File: rtl/wb_arbiter_64.sv
// wb_arbiter_64: merges ALU and buffered long-latency results onto the single regfile write port
module wb_arbiter_64
    import wb_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       alu_valid,
    input  logic [4:0]                 alu_rd,
    input  logic [63:0]                alu_data,
    input  logic                       lu_valid,
    output logic                       lu_ready,
    input  logic [4:0]                 lu_rd,
    input  logic [63:0]                lu_data,
    output logic                       reg_write,
    output logic [4:0]                 w_reg,
    output logic [63:0]                w_data,
    output logic                       alu_stall,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count
);
    localparam int             AGW      = $clog2(STARVE_LIMIT+1);
    localparam logic [AGW-1:0] AGE_MAX  = AGW'(STARVE_LIMIT);
    localparam logic [AGW-1:0] AGE_TRIP = AGW'(STARVE_LIMIT-1);

    wb_req_t         alu_req, head, sel;
    logic            empty, full, accept_alu, pop, push;
    logic            write_q, write_d, stall_q, stall_d;
    logic [4:0]      w_reg_q, w_reg_d;
    logic [63:0]     w_data_q, w_data_d;
    logic [AGW-1:0]  age_q, age_d;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .din_i   ('{rd: lu_rd, data: lu_data}),
        .pop_i   (pop),
        .head_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (fifo_count)
    );

    assign lu_ready  = !full;
    assign reg_write = write_q;
    assign w_reg     = w_reg_q;
    assign w_data    = w_data_q;
    assign alu_stall = stall_q;

    // A starved head pre-empts the ALU; otherwise the ALU wins and the FIFO drains into idle slots
    always_comb begin
        alu_req    = '{rd: alu_rd, data: alu_data};
        accept_alu = alu_valid && !stall_q;
        pop        = !empty && (stall_q || !accept_alu);
        push       = lu_valid && !full;
        sel        = pop ? head : alu_req;
        write_d    = (pop || accept_alu) && wb_writes(sel);
        w_reg_d    = write_d ? sel.rd : '0;
        w_data_d   = write_d ? sel.data : '0;
        age_d      = (empty || pop) ? '0 : (age_q == AGE_MAX) ? age_q : age_q + AGW'(1);
        stall_d    = !empty && !pop && (stall_q || age_q == AGE_TRIP);
    end

    // Registered write port, head age and stall; reset kills any write in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            write_q  <= 1'b0;
            w_reg_q  <= '0;
            w_data_q <= '0;
            age_q    <= '0;
            stall_q  <= 1'b0;
        end else begin
            write_q  <= write_d;
            w_reg_q  <= w_reg_d;
            w_data_q <= w_data_d;
            age_q    <= age_d;
            stall_q  <= stall_d;
        end
    end
endmodule

// File: tb/tb_wb_arbiter_64.sv
// tb_wb_arbiter_64: directed stimulus with an in-order expected-write scoreboard
module tb_wb_arbiter_64;
    import wb_pkg::*;

    logic        clk, reset;
    logic        alu_valid, lu_valid, lu_ready, reg_write, alu_stall;
    logic [4:0]  alu_rd, lu_rd, w_reg;
    logic [63:0] alu_data, lu_data, w_data;
    logic [2:0]  fifo_count;

    int checks = 0;
    int fails  = 0;
    wb_req_t exp_q[$];

    wb_arbiter_64 #(.DEPTH(4), .STARVE_LIMIT(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .alu_valid  (alu_valid),
        .alu_rd     (alu_rd),
        .alu_data   (alu_data),
        .lu_valid   (lu_valid),
        .lu_ready   (lu_ready),
        .lu_rd      (lu_rd),
        .lu_data    (lu_data),
        .reg_write  (reg_write),
        .w_reg      (w_reg),
        .w_data     (w_data),
        .alu_stall  (alu_stall),
        .fifo_count (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_valid = 1'b0;
        alu_rd    = '0;
        alu_data  = '0;
        lu_valid  = 1'b0;
        lu_rd     = '0;
        lu_data   = '0;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic expect_wr(input logic [4:0] rd, input logic [63:0] d);
        exp_q.push_back('{rd: rd, data: d});
    endtask

    // Every write the DUT presents must be the next expected one, in order
    always @(negedge clk) begin
        if (!reset && reg_write) begin
            checks++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_write: got rd=%0d data=%h required no write", w_reg, w_data);
            end else begin
                wb_req_t e;
                e = exp_q.pop_front();
                if (w_reg !== e.rd || w_data !== e.data) begin
                    fails++;
                    $display("FAIL write_order: got rd=%0d data=%h required rd=%0d data=%h",
                             w_reg, w_data, e.rd, e.data);
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        idle();
        #2;
        chk("rst_reg_write", 64'(reg_write), 0);
        chk("rst_w_reg", 64'(w_reg), 0);
        chk("rst_w_data", w_data, 0);
        chk("rst_alu_stall", 64'(alu_stall), 0);
        chk("rst_fifo_count", 64'(fifo_count), 0);
        chk("rst_lu_ready", 64'(lu_ready), 1);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Single ALU write appears one cycle later for exactly one cycle
        expect_wr(5, 64'hDEAD_BEEF);
        alu_valid = 1'b1;
        alu_rd    = 5;
        alu_data  = 64'hDEAD_BEEF;
        cyc();
        idle();
        chk("t1_pulse", 64'(reg_write), 1);
        cyc();
        chk("t1_pulse_end", 64'(reg_write), 0);
        repeat (2) cyc();

        // Four LU results with the ALU idle drain in order
        for (int r = 1; r <= 4; r++) expect_wr(5'(r), 64'h100 + 64'(r));
        for (int c = 0; c < 4; c++) begin
            lu_valid = 1'b1;
            lu_rd    = 5'(c + 1);
            lu_data  = 64'h100 + 64'(c + 1);
            chk("t2_lu_ready", 64'(lu_ready), 1);
            cyc();
        end
        idle();
        repeat (5) cyc();
        chk("t2_count_zero", 64'(fifo_count), 0);
        chk("t2_lu_ready_end", 64'(lu_ready), 1);

        // Busy ALU fills the FIFO and starves its head until the guard stalls the ALU
        for (int c = 0; c <= 8; c++) expect_wr(6, 64'hA0 + 64'(c));
        expect_wr(1, 64'h201);
        expect_wr(6, 64'hA9);
        for (int r = 2; r <= 5; r++) expect_wr(5'(r), 64'h200 + 64'(r));
        for (int c = 0; c <= 10; c++) begin
            alu_valid = 1'b1;
            alu_rd    = 6;
            alu_data  = 64'hA0 + 64'(c > 9 ? 9 : c);
            lu_valid  = 1'b1;
            lu_rd     = 5'(c < 4 ? c + 1 : 5);
            lu_data   = 64'h200 + 64'(lu_rd);
            if (c == 4) chk("t3_full_not_ready", 64'(lu_ready), 0);
            if (c == 4) chk("t3_count_full", 64'(fifo_count), 4);
            if (c == 8) chk("t3_no_stall_yet", 64'(alu_stall), 0);
            if (c == 9) chk("t3_stall_rises", 64'(alu_stall), 1);
            if (c == 9) chk("t3_no_push_when_full", 64'(fifo_count), 4);
            if (c == 10) chk("t3_stall_clears", 64'(alu_stall), 0);
            if (c == 10) chk("t3_ready_after_pop", 64'(lu_ready), 1);
            cyc();
        end
        idle();
        repeat (6) cyc();
        chk("t3_count_zero", 64'(fifo_count), 0);

        // x0 targets from both sources are consumed silently
        alu_valid = 1'b1;
        alu_rd    = 0;
        alu_data  = 64'h1234;
        lu_valid  = 1'b1;
        lu_rd     = 0;
        lu_data   = 64'h5678;
        cyc();
        idle();
        chk("t4_count_one", 64'(fifo_count), 1);
        chk("t4_alu_x0_we", 64'(reg_write), 0);
        chk("t4_alu_x0_reg", 64'(w_reg), 0);
        chk("t4_alu_x0_data", w_data, 0);
        cyc();
        chk("t4_lu_x0_we", 64'(reg_write), 0);
        chk("t4_lu_x0_reg", 64'(w_reg), 0);
        chk("t4_lu_x0_data", w_data, 0);
        chk("t4_count_zero", 64'(fifo_count), 0);
        repeat (2) cyc();

        // Simultaneous push and pop at count 2, with the pointers wrapping
        expect_wr(7, 64'h70);
        expect_wr(7, 64'h71);
        for (int r = 11; r <= 16; r++) expect_wr(5'(r), 64'hB0 + 64'(r));
        for (int c = 0; c < 6; c++) begin
            alu_valid = c < 2;
            alu_rd    = 7;
            alu_data  = 64'h70 + 64'(c);
            lu_valid  = 1'b1;
            lu_rd     = 5'(11 + c);
            lu_data   = 64'hB0 + 64'(11 + c);
            if (c >= 2) chk("t6_count_steady", 64'(fifo_count), 2);
            cyc();
        end
        idle();
        chk("t6_count_steady_end", 64'(fifo_count), 2);
        repeat (4) cyc();
        chk("t6_count_zero", 64'(fifo_count), 0);

        // Reset with three buffered entries drops them and clears outputs at once
        for (int c = 0; c < 3; c++) expect_wr(8, 64'h80 + 64'(c));
        for (int c = 0; c < 3; c++) begin
            alu_valid = 1'b1;
            alu_rd    = 8;
            alu_data  = 64'h80 + 64'(c);
            lu_valid  = 1'b1;
            lu_rd     = 5'(20 + c);
            lu_data   = 64'hC0 + 64'(c);
            cyc();
        end
        idle();
        chk("t5_count_three", 64'(fifo_count), 3);
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        chk("t5_async_we", 64'(reg_write), 0);
        chk("t5_async_reg", 64'(w_reg), 0);
        chk("t5_async_data", w_data, 0);
        chk("t5_async_stall", 64'(alu_stall), 0);
        chk("t5_async_count", 64'(fifo_count), 0);
        chk("t5_async_ready", 64'(lu_ready), 1);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (6) cyc();
        chk("t5_count_after", 64'(fifo_count), 0);

        chk("scoreboard_drained", 64'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/wb_arbiter_64.md
# wb_arbiter_64

Writeback arbiter driving the single write port of the 64-bit integer register file. Merges the single-cycle ALU result stream with results from long-latency units (multiplier/divider/load). Long-latency results are buffered in a small FIFO and drained in cycles the ALU leaves free. A starvation guard stalls the ALU when a buffered result has waited too long. Sits between execute/memory stages and the regfile `reg_write`/`w_reg`/`w_data` inputs.

## Interface
- `DEPTH`, 4: long-latency FIFO entries (power of two, ≥2)
- `STARVE_LIMIT`, 8: cycles a FIFO head may wait before ALU is stalled (≥1)
- `clk`  in  1  clock, all state on rising edge
- `reset`  in  1  asynchronous, active-high; one clock, reset is asynchronous and active-high
- `alu_valid`  in  1  ALU result present this cycle
- `alu_rd`  in  5  ALU destination register
- `alu_data`  in  64  ALU result
- `lu_valid`  in  1  long-latency result offered
- `lu_ready`  out  1  FIFO can accept (`count < DEPTH`)
- `lu_rd`  in  5  long-latency destination register
- `lu_data`  in  64  long-latency result
- `reg_write`  out  1  registered write enable to regfile
- `w_reg`  out  5  registered write register
- `w_data`  out  64  registered write data
- `alu_stall`  out  1  registered; ALU result not accepted while high
- `fifo_count`  out  $clog2(DEPTH+1)  current FIFO occupancy

## Operation
- LU push: `lu_valid && lu_ready` at an edge writes {`lu_rd`,`lu_data`} to FIFO tail.
- `lu_ready` depends only on occupancy; no push into a full FIFO even if a pop occurs the same cycle.
- ALU accepted when `alu_valid && !alu_stall`; otherwise the upstream pipeline holds and re-presents it.
- Per-cycle selection, in priority order:
  - `alu_stall` high and FIFO non-empty: pop head.
  - ALU accepted: write ALU result; FIFO not popped.
  - Otherwise, FIFO non-empty: pop head.
  - Otherwise: idle.
- x0 rule: a selected entry with rd==0 is consumed (popped or accepted) but produces `reg_write`=0, `w_reg`=0, `w_data`=0.
- Age counter: reset to 0 on every pop and whenever FIFO is empty; increments each cycle the head stays unpopped; saturates at `STARVE_LIMIT`.
- `alu_stall` next-state: 1 when age == `STARVE_LIMIT`-1 and head not popped this cycle; cleared on the cycle after the starved head is popped.
- FIFO pointers wrap modulo `DEPTH`; count is held separately. Simultaneous push and pop leaves count unchanged.

## Timing
- Reset values: `reg_write`=0, `w_reg`=0, `w_data`=0, `alu_stall`=0, `fifo_count`=0, `lu_ready`=1. FIFO empty, age=0.
- Reset asserted mid-operation discards all buffered results; no write occurs after reset assertion.
- ALU latency 1: accepted in cycle N, so `reg_write` is high in N+1.
- LU latency ≥2: pushed at the end of cycle N, head visible in N+1, written in N+2 at the earliest.
- `reg_write` is a single-cycle pulse per write; back-to-back writes are allowed every cycle.
- `lu_ready` and `fifo_count` reflect registered occupancy (no combinational path from `lu_valid`).
- FIFO ordering is strict; the LU stream is never reordered. ALU vs LU ordering is not preserved; hazard logic upstream owns this.

## Structure
- `wb_pkg`: `XLEN`=64, `REG_AW`=5, `typedef struct packed {logic [REG_AW-1:0] rd; logic [XLEN-1:0] data;} wb_req_t`.
- Sub-module `wb_fifo` (parameter `DEPTH`, element `wb_req_t`):
  - push/pop, `full`/`empty`/`count`
  - asynchronous active-high reset of pointers and count
- Top module: selection mux, age counter, stall register, output registers.

## Test plan
- Reset, then ALU rd=5 data=0xDEAD_BEEF for one cycle -> `reg_write`=1, `w_reg`=5, `w_data`=0xDEAD_BEEF one cycle later, for exactly one cycle.
- 4 LU pushes (rd=1..4) with ALU idle -> writes rd 1,2,3,4 in order; `fifo_count` returns to 0; `lu_ready` stays 1.
- ALU valid every cycle, 5 LU offers, `DEPTH`=4 -> `lu_ready`=0 after 4 pushes; `alu_stall` rises after `STARVE_LIMIT`=8 cycles of head wait; rd=1 written; stall clears next cycle.
- ALU rd=0 data=0x1234 and LU rd=0 -> both consumed, `reg_write` never 1, FIFO drains to 0.
- Reset asserted with 3 entries buffered -> all outputs 0 immediately (asynchronously); no writes after deassert until new input.
- Push and pop in the same cycle with count=2 -> count stays 2; pointer wrap across index `DEPTH`-1→0 preserves order.
